lockin_csr_bank: RTL
====================

LOCKIN_CSR_BANK -- requirements
Module: lockin_csr_bank

Interface
REQ-001 Parameter N_CH, default 8: number of lock-in channels, range 1..16.
REQ-002 Parameter PH_W, default 20: phase increment/offset width, range 1..32.
REQ-003 Parameter GAIN_W, default 6: gain control width, range 1..32.
REQ-004 Parameter LIA_W, default 16: lock-in X/Y result width, range 1..32.
REQ-005 Parameter RSTREQ_LEN, default 16: soft-reset pulse length in cycles, range 1..255.
REQ-006 clk_clk  in  1  sole clock; all logic rising-edge.
REQ-007 reset_reset_n  in  1  asynchronous active-low reset.
REQ-008 avs_address  in  7  word address.
REQ-009 avs_write / avs_read  in  1  Avalon-MM strobes; never asserted together.
REQ-010 avs_writedata  in  32  write data.
REQ-011 avs_readdata  out  32  read data.
REQ-012 avs_readdatavalid  out  1  read data qualifier.
REQ-013 sync_tick  in  1  single-cycle NCO phase-zero strobe.
REQ-014 lia_x_in / lia_y_in  in  N_CH*LIA_W  packed per-channel results; channel k occupies bits [k*LIA_W +: LIA_W].
REQ-015 phase_incr_out / phase_offs_out  out  N_CH*PH_W  packed active settings.
REQ-016 gain_ctrl_out  out  GAIN_W  active gain.
REQ-017 resetrequest_reset  out  1  active-high soft-reset request to the system.

Function
REQ-018 Map: 0x00 CTRL (W: bit0 COMMIT, bit1 SNAP, bit2 SOFTRST); 0x01 STATUS (R: bit0 pending, bit1 armed, bit2 rstreq); 0x02 GAIN shadow; 0x10+k INCR shadow; 0x20+k OFFS shadow; 0x30+k X snapshot; 0x40+k Y snapshot; k < N_CH.
REQ-019 Writes to shadow registers store writedata LSBs truncated to field width; upper bits are ignored.
REQ-020 Reads return fields zero-extended (X/Y sign-extended) to 32 bits; avs_readdatavalid asserts exactly 1 cycle after avs_read; unmapped or k >= N_CH addresses read 0 and ignore writes.
REQ-021 Any shadow write sets pending; COMMIT clears pending only when the commit FSM reaches APPLY.
REQ-022 Commit FSM states IDLE, ARMED, APPLY. IDLE -COMMIT-> ARMED; ARMED -sync_tick-> APPLY; APPLY -> IDLE unconditionally after 1 cycle.
REQ-023 In APPLY, all shadow registers (gain, every INCR/OFFS) copy to active outputs in the same cycle; outputs change together, one cycle after the sync_tick that triggered APPLY.
REQ-024 COMMIT and sync_tick in the same cycle in IDLE: enter ARMED only; that tick is not consumed.
REQ-025 COMMIT while ARMED or APPLY is ignored; shadow writes during ARMED are included in the pending apply.
REQ-026 SNAP latches all lia_x_in/lia_y_in into snapshot registers on the cycle after the write; a read of a snapshot address in the same cycle as SNAP returns the old value.
REQ-027 SOFTRST asserts resetrequest_reset for exactly RSTREQ_LEN cycles; SOFTRST during an active pulse restarts the count.
REQ-028 COMMIT, SNAP and SOFTRST set in one write all take effect independently.

Reset
REQ-029 reset_reset_n low asynchronously clears: shadow and active registers, snapshots, gain_ctrl_out, phase outputs, avs_readdatavalid and avs_readdata to 0; FSM to IDLE; pending 0; resetrequest_reset 0, counter 0.
REQ-030 Reset mid-ARMED abandons the commit; no partial apply occurs.

Structure
REQ-031 Package lockin_csr_pkg holds the address constants, CTRL/STATUS bit indices and the FSM state enum.
REQ-032 One sub-module, lockin_commit_fsm, implements REQ-022..025 and outputs an apply strobe.

Verification
REQ-033 Write INCR[3]=0x12345, COMMIT, sync_tick 10 cycles later -> phase_incr_out ch3 = 0x12345 on cycle 11, unchanged before.
REQ-034 Write OFFS[0]=0xFFFFF, COMMIT with simultaneous sync_tick -> no change; next sync_tick -> applied; STATUS.pending 1 then 0.
REQ-035 Drive ch7 lia_x = 0x8001, SNAP, read 0x37 -> readdata 0xFFFF8001, readdatavalid 1 cycle after read.
REQ-036 SOFTRST at t0, again at t0+5 -> resetrequest_reset high from t0+1 through t0+5+RSTREQ_LEN.
REQ-037 COMMIT, assert reset_reset_n low before sync_tick -> all outputs 0, FSM IDLE; later sync_tick causes no apply.
REQ-038 Read 0x10+N_CH and 0x7F -> readdata 0; writes there change nothing.

Source files
------------

// File: rtl/lockin_csr_pkg.sv
// Shared constants for the lock-in CSR bank: register map, CTRL/STATUS bit
// positions and the commit state machine encoding.
package lockin_csr_pkg;

  // Fixed single-word registers
  localparam logic [6:0] ADDR_CTRL   = 7'h00;
  localparam logic [6:0] ADDR_STATUS = 7'h01;
  localparam logic [6:0] ADDR_GAIN   = 7'h02;

  // Per-channel register groups live at <group>0 + k; group is address[6:4]
  localparam logic [2:0] GRP_INCR = 3'h1;
  localparam logic [2:0] GRP_OFFS = 3'h2;
  localparam logic [2:0] GRP_X    = 3'h3;
  localparam logic [2:0] GRP_Y    = 3'h4;

  // CTRL write bits
  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_SNAP    = 1;
  localparam int CTRL_SOFTRST = 2;

  // STATUS read bits
  localparam int STAT_PENDING = 0;
  localparam int STAT_ARMED   = 1;
  localparam int STAT_RSTREQ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } commit_state_e;

endpackage

// File: rtl/lockin_commit_fsm.sv
// Commit sequencer: COMMIT arms the bank, the next NCO phase-zero tick
// applies all shadow settings at once, then a one-cycle APPLY state
// returns to IDLE. apply_o fires on the cycle that transitions into APPLY,
// so the active registers load on the same edge the FSM enters APPLY.
import lockin_csr_pkg::*;

module lockin_commit_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic commit_i,
  input  logic sync_tick_i,
  output logic armed_o,
  output logic apply_o
);

  commit_state_e state_q, state_d;

  // State register; reset abandons any armed commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and apply strobe; a tick seen while IDLE is never consumed
  always_comb begin
    state_d = state_q;
    apply_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (sync_tick_i) begin
          state_d = ST_APPLY;
          apply_o = 1'b1;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign armed_o = (state_q == ST_ARMED);

endmodule

// File: rtl/lockin_csr_bank.sv
// Avalon-MM CSR bank for a multi-channel lock-in amplifier. Holds shadow
// NCO/gain settings that are applied atomically on an NCO sync tick,
// snapshots of the per-channel X/Y results, and a soft-reset pulse timer.
import lockin_csr_pkg::*;

module lockin_csr_bank #(
  parameter int N_CH       = 8,
  parameter int PH_W       = 20,
  parameter int GAIN_W     = 6,
  parameter int LIA_W      = 16,
  parameter int RSTREQ_LEN = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [6:0]             avs_address,
  input  logic                   avs_write,
  input  logic                   avs_read,
  input  logic [31:0]            avs_writedata,
  output logic [31:0]            avs_readdata,
  output logic                   avs_readdatavalid,
  input  logic                   sync_tick,
  input  logic [N_CH*LIA_W-1:0]  lia_x_in,
  input  logic [N_CH*LIA_W-1:0]  lia_y_in,
  output logic [N_CH*PH_W-1:0]   phase_incr_out,
  output logic [N_CH*PH_W-1:0]   phase_offs_out,
  output logic [GAIN_W-1:0]      gain_ctrl_out,
  output logic                   resetrequest_reset
);

  // Sign-extend a lock-in result to a 32-bit bus word
  function automatic logic [31:0] sext_lia(input logic [LIA_W-1:0] v);
    logic signed [LIA_W-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  logic [GAIN_W-1:0] gain_sh_q, gain_sh_d, gain_act_q, gain_act_d;
  logic [PH_W-1:0]   incr_sh_q [N_CH];
  logic [PH_W-1:0]   incr_sh_d [N_CH];
  logic [PH_W-1:0]   offs_sh_q [N_CH];
  logic [PH_W-1:0]   offs_sh_d [N_CH];
  logic [PH_W-1:0]   incr_act_q [N_CH];
  logic [PH_W-1:0]   incr_act_d [N_CH];
  logic [PH_W-1:0]   offs_act_q [N_CH];
  logic [PH_W-1:0]   offs_act_d [N_CH];
  logic [LIA_W-1:0]  snap_x_q [N_CH];
  logic [LIA_W-1:0]  snap_x_d [N_CH];
  logic [LIA_W-1:0]  snap_y_q [N_CH];
  logic [LIA_W-1:0]  snap_y_d [N_CH];

  logic        pending_q, pending_d;
  logic        snap_req_q, snap_req_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;

  logic [2:0]  grp;
  logic [3:0]  idx;
  logic        wr_ctrl;
  logic        commit_cmd, snap_cmd, softrst_cmd;
  logic        shadow_wr;
  logic        armed, apply;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign grp         = avs_address[6:4];
  assign idx         = avs_address[3:0];
  assign wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);
  assign commit_cmd  = wr_ctrl && avs_writedata[CTRL_COMMIT];
  assign snap_cmd    = wr_ctrl && avs_writedata[CTRL_SNAP];
  assign softrst_cmd = wr_ctrl && avs_writedata[CTRL_SOFTRST];
  // Upper write-data bits beyond field widths are intentionally discarded
  assign unused_wdata = ^avs_writedata;

  lockin_commit_fsm u_commit_fsm (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .commit_i    (commit_cmd),
    .sync_tick_i (sync_tick),
    .armed_o     (armed),
    .apply_o     (apply)
  );

  // Shadow register writes; out-of-range channel addresses match nothing
  always_comb begin
    gain_sh_d = gain_sh_q;
    incr_sh_d = incr_sh_q;
    offs_sh_d = offs_sh_q;
    shadow_wr = 1'b0;
    if (avs_write) begin
      if (avs_address == ADDR_GAIN) begin
        gain_sh_d = avs_writedata[GAIN_W-1:0];
        shadow_wr = 1'b1;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (idx == 4'(k) && grp == GRP_INCR) begin
          incr_sh_d[k] = avs_writedata[PH_W-1:0];
          shadow_wr    = 1'b1;
        end
        if (idx == 4'(k) && grp == GRP_OFFS) begin
          offs_sh_d[k] = avs_writedata[PH_W-1:0];
          shadow_wr    = 1'b1;
        end
      end
    end
  end

  // Active settings load all together on apply; pending tracks unapplied
  // shadow writes, and a write racing the apply keeps pending set
  always_comb begin
    gain_act_d = gain_act_q;
    incr_act_d = incr_act_q;
    offs_act_d = offs_act_q;
    pending_d  = pending_q;
    if (apply) begin
      gain_act_d = gain_sh_q;
      incr_act_d = incr_sh_q;
      offs_act_d = offs_sh_q;
      pending_d  = 1'b0;
    end
    if (shadow_wr) pending_d = 1'b1;
  end

  // Snapshot capture one cycle after the SNAP write; soft-reset countdown
  always_comb begin
    snap_req_d = snap_cmd;
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    if (snap_req_q) begin
      for (int k = 0; k < N_CH; k++) begin
        snap_x_d[k] = lia_x_in[k*LIA_W +: LIA_W];
        snap_y_d[k] = lia_y_in[k*LIA_W +: LIA_W];
      end
    end
    rst_cnt_d = rst_cnt_q;
    if (softrst_cmd)            rst_cnt_d = 8'(RSTREQ_LEN);
    else if (rst_cnt_q != 8'd0) rst_cnt_d = rst_cnt_q - 8'd1;
  end

  // Read mux and registered read response
  always_comb begin
    rd_val = '0;
    if (avs_address == ADDR_STATUS) begin
      rd_val[STAT_PENDING] = pending_q;
      rd_val[STAT_ARMED]   = armed;
      rd_val[STAT_RSTREQ]  = resetrequest_reset;
    end else if (avs_address == ADDR_GAIN) begin
      rd_val = 32'(gain_sh_q);
    end
    for (int k = 0; k < N_CH; k++) begin
      if (idx == 4'(k)) begin
        case (grp)
          GRP_INCR: rd_val = 32'(incr_sh_q[k]);
          GRP_OFFS: rd_val = 32'(offs_sh_q[k]);
          GRP_X:    rd_val = sext_lia(snap_x_q[k]);
          GRP_Y:    rd_val = sext_lia(snap_y_q[k]);
          default:  ;
        endcase
      end
    end
    readdata_d = avs_read ? rd_val : readdata_q;
    rdv_d      = avs_read;
  end

  // All state registers, cleared asynchronously
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      gain_sh_q  <= '0;
      gain_act_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        incr_sh_q[k]  <= '0;
        offs_sh_q[k]  <= '0;
        incr_act_q[k] <= '0;
        offs_act_q[k] <= '0;
        snap_x_q[k]   <= '0;
        snap_y_q[k]   <= '0;
      end
      pending_q  <= 1'b0;
      snap_req_q <= 1'b0;
      rst_cnt_q  <= 8'd0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      gain_sh_q  <= gain_sh_d;
      gain_act_q <= gain_act_d;
      incr_sh_q  <= incr_sh_d;
      offs_sh_q  <= offs_sh_d;
      incr_act_q <= incr_act_d;
      offs_act_q <= offs_act_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      pending_q  <= pending_d;
      snap_req_q <= snap_req_d;
      rst_cnt_q  <= rst_cnt_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign phase_incr_out[g*PH_W +: PH_W] = incr_act_q[g];
    assign phase_offs_out[g*PH_W +: PH_W] = offs_act_q[g];
  end

  assign gain_ctrl_out      = gain_act_q;
  assign resetrequest_reset = (rst_cnt_q != 8'd0);
  assign avs_readdata       = readdata_q;
  assign avs_readdatavalid  = rdv_q;

endmodule
